// File: rtl/cacheline_burst_adapter.sv
// Adapts 256-bit cache line reads/writes into 4-beat, 64-bit memory bursts.
// One transaction at a time; the line buffer doubles as read assembly and write source.
module cacheline_burst_adapter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e        state_q, state_d;
  logic [1:0]    beat_cnt_q, beat_cnt_d;
  logic [255:0]  line_q, line_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    beat_base;

  // Offset bits are dropped by line alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[4:0];

  assign beat_base = {beat_cnt_q, 6'b0};

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    line_d     = line_q;
    addr_d     = addr_q;
    unique case (state_q)
      StIdle: begin
        // Write has priority when both requests arrive together.
        if (write_i) begin
          addr_d     = {address_i[31:5], 5'b0};
          line_d     = line_i;
          beat_cnt_d = 2'd0;
          state_d    = StWrite;
        end else if (read_i) begin
          addr_d     = {address_i[31:5], 5'b0};
          beat_cnt_d = 2'd0;
          state_d    = StRead;
        end
      end
      StRead: begin
        if (resp_i) begin
          line_d[beat_base +: 64] = burst_i;
          beat_cnt_d              = beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) state_d = StDone;
        end
      end
      StWrite: begin
        if (resp_i) begin
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      beat_cnt_q <= 2'd0;
      line_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    read_o    = (state_q == StRead);
    write_o   = (state_q == StWrite);
    resp_o    = (state_q == StDone);
    line_o    = line_q;
    address_o = addr_q;
    burst_o   = (state_q == StWrite) ? line_q[beat_base +: 64] : 64'd0;
  end

endmodule

// File: doc/cacheline_burst_adapter.md
CACHELINE_BURST_ADAPTER -- requirements
Module: cacheline_burst_adapter

Interface
REQ-001 The block SHALL have no parameters; line width is fixed at 256 bits, burst width at 64 bits, and burst length at 4 beats.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 line_i  input  256  cache line to be written to memory, sampled when a write is accepted.
REQ-005 line_o  output  256  cache line assembled from a read burst.
REQ-006 address_i  input  32  cache-side byte address.
REQ-007 read_i  input  1  cache-side line read request.
REQ-008 write_i  input  1  cache-side line write request.
REQ-009 resp_o  output  1  one-cycle completion pulse to the cache.
REQ-010 burst_i  input  64  memory-side read beat data.
REQ-011 burst_o  output  64  memory-side write beat data.
REQ-012 address_o  output  32  memory-side address, 32-byte aligned.
REQ-013 read_o  output  1  memory-side burst read request.
REQ-014 write_o  output  1  memory-side burst write request.
REQ-015 resp_i  input  1  memory-side per-beat acknowledge.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, READ, WRITE and DONE.
REQ-017 In IDLE, write_i=1 SHALL be accepted on the rising edge: latch {address_i[31:5],5'b0} into address_o, latch line_i into the line buffer, clear beat_cnt, and go to WRITE.
REQ-018 In IDLE, read_i=1 with write_i=0 SHALL be accepted on the rising edge: latch the aligned address, clear beat_cnt, and go to READ.
REQ-019 When read_i and write_i are both high in IDLE, the write SHALL be accepted and the read ignored.
REQ-020 read_o SHALL be 1 only in READ, and write_o SHALL be 1 only in WRITE; both SHALL be registered state decodes.
REQ-021 In READ, each edge with resp_i=1 SHALL store burst_i into buffer bits [64*beat_cnt +: 64] and increment the 2-bit beat_cnt.
REQ-022 In WRITE, burst_o SHALL equal buffer bits [64*beat_cnt +: 64] combinationally, and each edge with resp_i=1 SHALL increment beat_cnt.
REQ-023 Beat order SHALL be beat 0 = bits [63:0] up to beat 3 = bits [255:192].
REQ-024 The edge that samples resp_i=1 with beat_cnt=3 SHALL move the FSM to DONE, so that read_o/write_o deassert in the following cycle.
REQ-025 A cycle with resp_i=0 in READ or WRITE SHALL hold all state and outputs; stalls of any length SHALL be tolerated.
REQ-026 In DONE, resp_o SHALL be 1 for exactly one cycle, the FSM SHALL return to IDLE unconditionally, and read_i/write_i SHALL be ignored.
REQ-027 line_o SHALL equal the line buffer, and SHALL hold the last assembled line from DONE until the next accepted request modifies the buffer.
REQ-028 resp_i SHALL be ignored in IDLE and DONE.
REQ-029 address_o SHALL hold its latched value until the next accepted request.
REQ-030 With resp_i held at 1, the memory request SHALL be high for exactly 4 cycles, and resp_o SHALL be high in the 5th cycle after the accepting edge.

Reset
REQ-031 While rst_n=0, the block SHALL set the state to IDLE, beat_cnt to 0, the line buffer to 0, and address_o to 0, and SHALL drive read_o=0, write_o=0, resp_o=0, line_o=0, and burst_o=0.
REQ-032 Reset asserted mid-burst SHALL immediately drop read_o/write_o, SHALL NOT produce a resp_o pulse, and SHALL abandon the transaction.
REQ-033 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-034 Read, no stalls: read_i=1, address_i=0x0000_1234, burst_i=0x11..11/0x22..22/0x33..33/0x44..44 with resp_i=1 -> address_o=0x0000_1220, read_o high for 4 cycles, 1-cycle resp_o pulse, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-035 Write with stalls: line_i={D3,D2,D1,D0}, resp_i pattern 1,0,0,1,1,0,1 -> burst_o = D0,D1,D1,D1,D2,D3,D3 and write_o drops after the 7th cycle -> single resp_o pulse.
REQ-036 Simultaneous read_i=1 and write_i=1 in IDLE -> write_o asserts, read_o stays 0, and line_o is unchanged by any burst_i data.
REQ-037 rst_n pulsed low after 2 read beats -> read_o=0 and line_o=0 immediately, no resp_o pulse; a following read completes normally with fresh data.
REQ-038 read_i held high through DONE -> no request accepted in the DONE cycle, and a new READ begins at the edge after return to IDLE; resp_i=1 in IDLE -> no state change.
